// File: rtl/rl_fifo_ram_pkg.sv
// rl_fifo_ram_pkg
//   Shared helpers for the RAM-backed FIFO controller and its output buffer.
//   - be_width()  : byte-enable width for a given data width.
//   - ptr_width() : pointer width for a given RAM address width.
//                   The extra MSB is the wrap bit that tells full from empty.
package rl_fifo_ram_pkg;

  function automatic int be_width(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  function automatic int ptr_width(input int abits);
    return abits + 1;
  endfunction

endpackage

// File: rtl/rl_fifo_ram_obuf.sv
// rl_fifo_ram_obuf
//   Two-entry show-ahead output buffer (output register + skid register).
//   It hides the one-cycle registered-read latency of the RAM. The upstream
//   read-issue logic guarantees that a capture never arrives while both
//   entries are full and nothing pops.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous clear of both valid bits (reset or flush)
//   cap_valid  a word arrives this cycle (RAM read data or fall-through)
//   cap_data   the arriving word
//   pop        consumer takes the output word this cycle
//   out_valid  output register holds a word
//   skid_valid skid register holds a word (always behind out)
//   out_data   output register contents
module rl_fifo_ram_obuf
  import rl_fifo_ram_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_valid,
  input  logic [DBITS-1:0] cap_data,
  input  logic             pop,
  output logic             out_valid,
  output logic             skid_valid,
  output logic [DBITS-1:0] out_data
);

  logic [DBITS-1:0] skid_data;
  logic             cap_to_out;
  logic             cap_to_skid;

  // A capture lands in out only if out is free after this cycle's pop and
  // nothing older is waiting in skid; otherwise it queues behind in skid.
  assign cap_to_out  = cap_valid & ((!out_valid) | (pop & !skid_valid));
  assign cap_to_skid = cap_valid & ((pop & skid_valid) | (!pop & out_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= cap_valid;
      end else begin
        out_valid  <= cap_valid;
      end
    end else if (cap_valid) begin
      if (!out_valid) out_valid  <= 1'b1;
      else            skid_valid <= 1'b1;
    end
  end

  // Data registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (pop && skid_valid) out_data <= skid_data;
    else if (cap_to_out)   out_data <= cap_data;
    if (cap_to_skid)       skid_data <= cap_data;
  end

endmodule

// File: rtl/rl_fifo_ram_ctrl.sv
// rl_fifo_ram_ctrl
//   Valid/ready FIFO controller in front of an external 1R1W block RAM with a
//   registered (1-cycle) read port. Owns both RAM ports, the pointers and a
//   2-entry output buffer, presenting a show-ahead stream downstream.
//   Capacity is 2**ABITS + 2 words.
//
//   Optional build macro RL_FIFO_RAM_CTRL_FALLTHROUGH_EN: when the FIFO is
//   drained, a pushed word bypasses the RAM and goes straight to the output
//   register (1-cycle latency instead of 3). Capacity and count_o unchanged.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          synchronous clear of all contents
//   s_valid_i/s_ready_o/s_data_i   input stream
//   m_valid_o/m_ready_i/m_data_o   output stream (show-ahead)
//   count_o          words held (RAM + in-flight read + output buffer)
//   almost_full_o    count_o >= AFULL_LVL
//   ram_*            RAM write port (waddr/din/we/be) and read port
//                    (raddr out, dout back one cycle later)
module rl_fifo_ram_ctrl
  import rl_fifo_ram_pkg::*;
#(
  parameter int ABITS     = 4,
  parameter int DBITS     = 32,
  parameter int AFULL_LVL = 2**ABITS - 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [DBITS-1:0]           s_data_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DBITS-1:0]           m_data_o,
  output logic [ABITS+1:0]           count_o,
  output logic                       almost_full_o,
  output logic [ABITS-1:0]           ram_waddr_o,
  output logic [DBITS-1:0]           ram_din_o,
  output logic                       ram_we_o,
  output logic [be_width(DBITS)-1:0] ram_be_o,
  output logic [ABITS-1:0]           ram_raddr_o,
  input  logic [DBITS-1:0]           ram_dout_i
);

  localparam int PW = ptr_width(ABITS);
  localparam int CW = ABITS + 2;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t RAM_DEPTH = ptr_t'(2**ABITS);

  ptr_t             wr_ptr, rd_ptr, ram_cnt;
  logic             ram_full, ram_empty;
  logic             push, pop, ram_push, rd_en, ft, clr;
  logic             pending;
  logic             out_valid, skid_valid;
  logic [1:0]       occ;
  logic             cap_valid;
  logic [DBITS-1:0] cap_data;
  logic [CW-1:0]    count_q;

  assign clr       = rst_i | flush_i;

  // Wrap-bit pointers: difference is the RAM occupancy, modulo arithmetic
  // handles wrap-around without special cases.
  assign ram_cnt   = wr_ptr - rd_ptr;
  assign ram_full  = (ram_cnt == RAM_DEPTH);
  assign ram_empty = (wr_ptr == rd_ptr);

  // Ready depends on registered pointers only, so there is no comb path
  // from m_ready_i or s_valid_i.
  assign s_ready_o = !ram_full;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = out_valid & m_ready_i;

`ifdef RL_FIFO_RAM_CTRL_FALLTHROUGH_EN
  // Bypass only when nothing older exists anywhere, so order is preserved.
  assign ft = push & ram_empty & !pending & !skid_valid & (!out_valid | pop);
`else
  assign ft = 1'b0;
`endif

  assign ram_push  = push & !ft;

  // Words already outside the RAM (or on their way out). A new read is
  // issued only if, after this cycle's pop, the buffer still has a free slot
  // for the returning data.
  assign occ   = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pending};
  assign rd_en = !ram_empty & ({1'b0, occ} < (3'd2 + {2'b0, pop}));

  // RAM ports. A word written at one edge is read at the earliest in the next
  // cycle, so the read never collides with a write to the same address.
  assign ram_we_o    = ram_push;
  assign ram_waddr_o = wr_ptr[ABITS-1:0];
  assign ram_din_o   = s_data_i;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rd_ptr[ABITS-1:0];

  // pending and fall-through are mutually exclusive (ft requires !pending).
  assign cap_valid = pending | ft;
  assign cap_data  = ft ? s_data_i : ram_dout_i;

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= 1'b0;
      count_q <= '0;
    end else begin
      if (ram_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_en)    rd_ptr <= rd_ptr + ptr_t'(1);
      pending <= rd_en;
      // Tracks ram_cnt + pending + out_valid + skid_valid incrementally.
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // A read in flight at reset/flush is dropped: clr forces the buffer empty
  // and the stale data has nowhere to land since pending is cleared too.
  rl_fifo_ram_obuf #(
    .DBITS (DBITS)
  ) u_obuf (
    .clk        (clk_i),
    .rst        (clr),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .pop        (pop),
    .out_valid  (out_valid),
    .skid_valid (skid_valid),
    .out_data   (m_data_o)
  );

  assign m_valid_o     = out_valid;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CW'(AFULL_LVL));

endmodule
